// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory opcodes, arbiter state encoding and the
// default data-memory address width.
package cpu_pkg;

  localparam int MEM_AW_DEF = 12;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_lane_dec.sv
// Per-slot memory-op decoder: classifies the instruction and forms the
// effective word address, range flag, store data and load destination.
module mem_lane_dec
  import cpu_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEF
) (
  input  logic [31:0]       ins,
  input  logic [31:0]       rs,
  input  logic [31:0]       rt,
  output logic              is_lw,
  output logic              is_sw,
  output logic [MEM_AW-1:0] addr,
  output logic              oor,
  output logic [31:0]       wdata,
  output logic [4:0]        rd
);

  logic [31:0] full_addr_s;

  // Opcode classification.
  always_comb begin
    is_lw = 1'b0;
    is_sw = 1'b0;
    case (ins[31:26])
      OP_LW:   is_lw = 1'b1;
      OP_SW:   is_sw = 1'b1;
      default: begin
        is_lw = 1'b0;
        is_sw = 1'b0;
      end
    endcase
  end

  // Effective address with 32-bit wrap; anything above the word index is out of range.
  always_comb begin
    full_addr_s = rs + {{16{ins[15]}}, ins[15:0]};
    addr        = full_addr_s[MEM_AW-1:0];
    oor         = |full_addr_s[31:MEM_AW];
    wdata       = rt;
    rd          = ins[20:16];
  end

endmodule

// File: rtl/mem_arb.sv
// Dual-issue single-port data-memory arbiter: serves slot 0 first, defers a
// conflicting slot-1 op by one stalled cycle, and returns load write-backs.
module mem_arb
  import cpu_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ins0,
  input  logic [31:0]       rs0,
  input  logic [31:0]       rt0,
  input  logic [31:0]       ins1,
  input  logic [31:0]       rs1,
  input  logic [31:0]       rt1,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              wb0_valid,
  output logic [4:0]        wb0_addr,
  output logic [31:0]       wb0_data,
  output logic              wb1_valid,
  output logic [4:0]        wb1_addr,
  output logic [31:0]       wb1_data,
  output logic              err,
  output logic [15:0]       conf_cnt
);

  logic              l0_is_lw_s, l0_is_sw_s, l0_oor_s;
  logic              l1_is_lw_s, l1_is_sw_s, l1_oor_s;
  logic [MEM_AW-1:0] l0_addr_s, l1_addr_s;
  logic [31:0]       l0_wdata_s, l1_wdata_s;
  logic [4:0]        l0_rd_s, l1_rd_s;

  mem_lane_dec #(.MEM_AW(MEM_AW)) u_dec0 (
    .ins(ins0), .rs(rs0), .rt(rt0),
    .is_lw(l0_is_lw_s), .is_sw(l0_is_sw_s), .addr(l0_addr_s),
    .oor(l0_oor_s), .wdata(l0_wdata_s), .rd(l0_rd_s)
  );

  mem_lane_dec #(.MEM_AW(MEM_AW)) u_dec1 (
    .ins(ins1), .rs(rs1), .rt(rt1),
    .is_lw(l1_is_lw_s), .is_sw(l1_is_sw_s), .addr(l1_addr_s),
    .oor(l1_oor_s), .wdata(l1_wdata_s), .rd(l1_rd_s)
  );

  arb_state_e        state_r, state_nxt_s;
  logic              latch_s;
  logic              pend_is_lw_r, pend_is_sw_r, pend_oor_r;
  logic [MEM_AW-1:0] pend_addr_r;
  logic [31:0]       pend_wdata_r;
  logic [4:0]        pend_rd_r;

  logic              srv_valid_s, srv_slot_s, srv_is_lw_s, srv_is_sw_s, srv_oor_s;
  logic [MEM_AW-1:0] srv_addr_s;
  logic [31:0]       srv_wdata_s;
  logic [4:0]        srv_rd_s;

  logic              wb0_valid_r, wb0_oor_r, wb1_valid_r, wb1_oor_r, err_r;
  logic [4:0]        wb0_addr_r, wb1_addr_r;
  logic [15:0]       conf_cnt_r;

  // Next state and selection of the op served this cycle.
  always_comb begin
    state_nxt_s = state_r;
    latch_s     = 1'b0;
    srv_valid_s = 1'b0;
    srv_slot_s  = 1'b0;
    srv_is_lw_s = 1'b0;
    srv_is_sw_s = 1'b0;
    srv_oor_s   = 1'b0;
    srv_addr_s  = '0;
    srv_wdata_s = 32'd0;
    srv_rd_s    = 5'd0;
    case (state_r)
      IDLE: begin
        if (l0_is_lw_s || l0_is_sw_s) begin
          srv_valid_s = 1'b1;
          srv_slot_s  = 1'b0;
          srv_is_lw_s = l0_is_lw_s;
          srv_is_sw_s = l0_is_sw_s;
          srv_oor_s   = l0_oor_s;
          srv_addr_s  = l0_addr_s;
          srv_wdata_s = l0_wdata_s;
          srv_rd_s    = l0_rd_s;
          if (l1_is_lw_s || l1_is_sw_s) begin
            state_nxt_s = HOLD;
            latch_s     = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (l1_is_lw_s || l1_is_sw_s) begin
          srv_valid_s = 1'b1;
          srv_slot_s  = 1'b1;
          srv_is_lw_s = l1_is_lw_s;
          srv_is_sw_s = l1_is_sw_s;
          srv_oor_s   = l1_oor_s;
          srv_addr_s  = l1_addr_s;
          srv_wdata_s = l1_wdata_s;
          srv_rd_s    = l1_rd_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HOLD: begin
        srv_valid_s = 1'b1;
        srv_slot_s  = 1'b1;
        srv_is_lw_s = pend_is_lw_r;
        srv_is_sw_s = pend_is_sw_r;
        srv_oor_s   = pend_oor_r;
        srv_addr_s  = pend_addr_r;
        srv_wdata_s = pend_wdata_r;
        srv_rd_s    = pend_rd_r;
        state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Memory port drive; reset is folded in so the port stays quiet while held.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    if (rst && srv_valid_s && !srv_oor_s) begin
      mem_en   = 1'b1;
      mem_addr = srv_addr_s;
      if (srv_is_sw_s) begin
        mem_we    = 1'b1;
        mem_wdata = srv_wdata_s;
      end else begin
        mem_we    = 1'b0;
        mem_wdata = 32'd0;
      end
    end else begin
      mem_en = 1'b0;
    end
  end

  // State, pending slot-1 op and conflict counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      pend_is_lw_r <= 1'b0;
      pend_is_sw_r <= 1'b0;
      pend_oor_r   <= 1'b0;
      pend_addr_r  <= '0;
      pend_wdata_r <= 32'd0;
      pend_rd_r    <= 5'd0;
      conf_cnt_r   <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      if (latch_s) begin
        pend_is_lw_r <= l1_is_lw_s;
        pend_is_sw_r <= l1_is_sw_s;
        pend_oor_r   <= l1_oor_s;
        pend_addr_r  <= l1_addr_s;
        pend_wdata_r <= l1_wdata_s;
        pend_rd_r    <= l1_rd_s;
        if (conf_cnt_r != 16'hFFFF) begin
          conf_cnt_r <= conf_cnt_r + 16'd1;
        end
      end
    end
  end

  // Write-back tags and error pulse, one cycle after the served access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb0_valid_r <= 1'b0;
      wb0_oor_r   <= 1'b0;
      wb0_addr_r  <= 5'd0;
      wb1_valid_r <= 1'b0;
      wb1_oor_r   <= 1'b0;
      wb1_addr_r  <= 5'd0;
      err_r       <= 1'b0;
    end else begin
      wb0_valid_r <= srv_valid_s && srv_is_lw_s && !srv_slot_s;
      wb0_oor_r   <= srv_oor_s;
      wb0_addr_r  <= (srv_valid_s && srv_is_lw_s && !srv_slot_s) ? srv_rd_s : 5'd0;
      wb1_valid_r <= srv_valid_s && srv_is_lw_s && srv_slot_s;
      wb1_oor_r   <= srv_oor_s;
      wb1_addr_r  <= (srv_valid_s && srv_is_lw_s && srv_slot_s) ? srv_rd_s : 5'd0;
      err_r       <= srv_valid_s && srv_oor_s;
    end
  end

  // Load data arrives from the memory the cycle after the access; out-of-range loads return zero.
  always_comb begin
    if (wb0_valid_r && !wb0_oor_r) begin
      wb0_data = mem_rdata;
    end else begin
      wb0_data = 32'd0;
    end
    if (wb1_valid_r && !wb1_oor_r) begin
      wb1_data = mem_rdata;
    end else begin
      wb1_data = 32'd0;
    end
  end

  assign stall     = (state_r == HOLD);
  assign wb0_valid = wb0_valid_r;
  assign wb0_addr  = wb0_addr_r;
  assign wb1_valid = wb1_valid_r;
  assign wb1_addr  = wb1_addr_r;
  assign err       = err_r;
  assign conf_cnt  = conf_cnt_r;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a synchronous single-port memory model.
module tb_mem_arb;
  import cpu_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins0, rs0, rt0, ins1, rs1, rt1;
  logic        stall, mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        wb0_valid, wb1_valid, err;
  logic [4:0]  wb0_addr, wb1_addr;
  logic [31:0] wb0_data, wb1_data;
  logic [15:0] conf_cnt;
  logic        mem_clr;
  logic [31:0] mem [0:4095];

  int vectors = 0;
  int miscompares = 0;

  mem_arb #(.MEM_AW(12)) dut (
    .clk(clk), .rst(rst),
    .ins0(ins0), .rs0(rs0), .rt0(rt0),
    .ins1(ins1), .rs1(rs1), .rt1(rt1),
    .stall(stall), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .err(err), .conf_cnt(conf_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'd0;
      mem_rdata <= 32'd0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] off);
    return {op, 5'd0, rt, off};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nops();
    ins0 = NOP; rs0 = 32'd0; rt0 = 32'd0;
    ins1 = NOP; rs1 = 32'd0; rt1 = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; mem_clr = 1'b1;
    nops();
    tick(); tick();
    chk("rst_stall", stall, 32'd0);
    chk("rst_wb0v", wb0_valid, 32'd0);
    chk("rst_wb1v", wb1_valid, 32'd0);
    chk("rst_wb0d", wb0_data, 32'd0);
    chk("rst_err", err, 32'd0);
    chk("rst_cnt", conf_cnt, 32'd0);
    chk("rst_men", mem_en, 32'd0);
    mem_clr = 1'b0;
    rst = 1'b1;

    // Preload mem[12]=0xAA through the arbiter.
    ins0 = enc(OP_SW, 5'd1, 16'd12); rt0 = 32'hAA;
    #2;
    chk("pre_men", mem_en, 32'd1);
    chk("pre_mwe", mem_we, 32'd1);
    chk("pre_addr", mem_addr, 32'd12);
    chk("pre_wdata", mem_wdata, 32'hAA);
    tick(); nops();
    chk("pre_mem12", mem[12], 32'hAA);
    chk("pre_wb0v", wb0_valid, 32'd0);

    // Single slot-0 load plus a non-memory slot 1.
    ins0 = enc(OP_LW, 5'd5, 16'd4); rs0 = 32'd8;
    #2;
    chk("lw_men", mem_en, 32'd1);
    chk("lw_mwe", mem_we, 32'd0);
    chk("lw_addr", mem_addr, 32'd12);
    chk("lw_stall", stall, 32'd0);
    tick(); nops();
    chk("lw_wb0v", wb0_valid, 32'd1);
    chk("lw_wb0a", wb0_addr, 32'd5);
    chk("lw_wb0d", wb0_data, 32'hAA);
    chk("lw_wb1v", wb1_valid, 32'd0);
    tick();
    chk("lw_wb0v_once", wb0_valid, 32'd0);

    // sw then lw to the same address: conflict, slot 1 reads new data.
    ins0 = enc(OP_SW, 5'd2, 16'd3); rt0 = 32'h11;
    ins1 = enc(OP_LW, 5'd7, 16'd3);
    #2;
    chk("cf_mwe", mem_we, 32'd1);
    chk("cf_addr", mem_addr, 32'd3);
    chk("cf_wdata", mem_wdata, 32'h11);
    chk("cf_stall0", stall, 32'd0);
    tick();
    chk("cf_stall1", stall, 32'd1);
    chk("cf_cnt", conf_cnt, 32'd1);
    ins0 = enc(OP_SW, 5'd1, 16'd5); rt0 = 32'hDEAD; ins1 = NOP;
    #1;
    chk("cf_hold_men", mem_en, 32'd1);
    chk("cf_hold_mwe", mem_we, 32'd0);
    chk("cf_hold_addr", mem_addr, 32'd3);
    chk("cf_hold_wb1v", wb1_valid, 32'd0);
    tick(); nops();
    chk("cf_wb1v", wb1_valid, 32'd1);
    chk("cf_wb1a", wb1_addr, 32'd7);
    chk("cf_wb1d", wb1_data, 32'h11);
    chk("cf_stall2", stall, 32'd0);
    chk("cf_mem5", mem[5], 32'd0);
    tick();
    chk("cf_wb1v_once", wb1_valid, 32'd0);

    // Two stores to the same address: slot-1 value wins.
    ins0 = enc(OP_SW, 5'd1, 16'd9); rt0 = 32'h1;
    ins1 = enc(OP_SW, 5'd2, 16'd9); rt1 = 32'h2;
    tick(); nops(); tick();
    chk("ss_mem9", mem[9], 32'h2);
    chk("ss_cnt", conf_cnt, 32'd2);

    // Slot-1 load alone, destination r0.
    ins1 = enc(OP_LW, 5'd0, 16'd12);
    #2;
    chk("l1_addr", mem_addr, 32'd12);
    chk("l1_stall", stall, 32'd0);
    tick(); nops();
    chk("l1_wb1v", wb1_valid, 32'd1);
    chk("l1_wb1a", wb1_addr, 32'd0);
    chk("l1_wb1d", wb1_data, 32'hAA);
    chk("l1_wb0v", wb0_valid, 32'd0);

    // Out-of-range load.
    ins0 = enc(OP_LW, 5'd6, 16'd0); rs0 = 32'h1000;
    #2;
    chk("oor_men", mem_en, 32'd0);
    chk("oor_err0", err, 32'd0);
    tick(); nops();
    chk("oor_err1", err, 32'd1);
    chk("oor_wb0v", wb0_valid, 32'd1);
    chk("oor_wb0a", wb0_addr, 32'd6);
    chk("oor_wb0d", wb0_data, 32'd0);
    tick();
    chk("oor_err2", err, 32'd0);

    // Reset while holding a pending slot-1 store.
    ins0 = enc(OP_SW, 5'd1, 16'd20); rt0 = 32'h55;
    ins1 = enc(OP_SW, 5'd2, 16'd21); rt1 = 32'h66;
    tick();
    chk("rh_stall1", stall, 32'd1);
    rst = 1'b0; nops();
    #1;
    chk("rh_stall0", stall, 32'd0);
    chk("rh_men", mem_en, 32'd0);
    chk("rh_cnt", conf_cnt, 32'd0);
    tick(); tick();
    rst = 1'b1;
    chk("rh_mem20", mem[20], 32'h55);
    chk("rh_mem21", mem[21], 32'd0);
    chk("rh_wb1v", wb1_valid, 32'd0);

    // Saturation of the conflict counter.
    force dut.conf_cnt_r = 16'hFFFF;
    #1;
    release dut.conf_cnt_r;
    #1;
    chk("sat_pre", conf_cnt, 32'hFFFF);
    ins0 = enc(OP_LW, 5'd1, 16'd9);
    ins1 = enc(OP_LW, 5'd2, 16'd12);
    tick(); nops();
    chk("sat_cnt", conf_cnt, 32'hFFFF);
    chk("sat_stall", stall, 32'd1);
    chk("sat_wb0d", wb0_data, 32'h2);
    tick();
    chk("sat_wb1a", wb1_addr, 32'd2);
    chk("sat_wb1d", wb1_data, 32'hAA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
